// File: rtl/adc_peak_mon.sv
// ADC peak / overflow monitor: registers the raw sample stream, stretches the
// ADC overrange flag for a slower clock domain, and captures per-window peak
// magnitude and overflow count into a valid/ack snapshot.
module adc_peak_mon #(
  parameter int ADC_W   = 14,
  parameter int STRETCH = 4
) (
  input  logic                    adc_clk,
  input  logic                    rst_n,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_ovfl,
  input  logic [15:0]             win_len,
  input  logic                    clear,
  output logic signed [ADC_W-1:0] data_out,
  output logic                    ovfl_out,
  output logic                    snap_valid,
  input  logic                    snap_ack,
  output logic [ADC_W-1:0]        snap_peak,
  output logic [15:0]             snap_ovfl_cnt,
  output logic                    snap_lost
);

  localparam int SW = $clog2(STRETCH + 1);

  // start = 1 means this cycle opens a new window: win_len is sampled now and
  // the accumulators are treated as empty, so the opening sample still counts.
  logic              start;
  logic [15:0]       win_cnt;
  logic [ADC_W-1:0]  peak_acc;
  logic [15:0]       ovf_acc;
  logic [SW-1:0]     s_cnt;

  logic [ADC_W-1:0]  raw, mag, peak_base, peak_nxt;
  logic [15:0]       cnt_eff, ovf_base, ovf_nxt;
  logic              term, capture, drop;

  // Window bookkeeping, magnitude and capture decisions for this cycle
  always_comb begin
    raw       = adc_data;
    // The most negative code negates to itself, which read unsigned is the
    // correct magnitude 2^(ADC_W-1); no extra bit needed.
    mag       = raw[ADC_W-1] ? (~raw + 1'b1) : raw;
    cnt_eff   = start ? win_len : win_cnt;
    peak_base = start ? '0 : peak_acc;
    ovf_base  = start ? '0 : ovf_acc;
    peak_nxt  = (mag > peak_base) ? mag : peak_base;
    ovf_nxt   = (adc_ovfl && ovf_base != 16'hFFFF) ? ovf_base + 16'd1 : ovf_base;
    term      = (cnt_eff == 16'd0);
    // A clear on the terminal cycle swallows that window entirely.
    capture   = term && !clear && (!snap_valid || snap_ack);
    drop      = term && !clear && snap_valid && !snap_ack;
  end

  // Sample pipeline register toward the receiver
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) data_out <= '0;
    else        data_out <= adc_data;
  end

  // Window counter and accumulators; restart after terminal cycle or clear
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      start    <= 1'b1;
      win_cnt  <= '0;
      peak_acc <= '0;
      ovf_acc  <= '0;
    end else if (term || clear) begin
      start    <= 1'b1;
      peak_acc <= '0;
      ovf_acc  <= '0;
    end else begin
      start    <= 1'b0;
      win_cnt  <= cnt_eff - 16'd1;
      peak_acc <= peak_nxt;
      ovf_acc  <= ovf_nxt;
    end
  end

  // Snapshot registers with valid/ack handshake and sticky drop flag
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_valid    <= 1'b0;
      snap_peak     <= '0;
      snap_ovfl_cnt <= '0;
      snap_lost     <= 1'b0;
    end else begin
      if (capture) begin
        snap_valid    <= 1'b1;
        snap_peak     <= peak_nxt;
        snap_ovfl_cnt <= ovf_nxt;
      end else if (snap_valid && snap_ack) begin
        snap_valid    <= 1'b0;
      end
      if (drop)                         snap_lost <= 1'b1;
      else if (snap_valid && snap_ack)  snap_lost <= 1'b0;
    end
  end

  // Overflow stretcher; ovfl_out is a flop so the cpu_clk synchroniser never
  // sees decode glitches from the multi-bit counter.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt    <= '0;
      ovfl_out <= 1'b0;
    end else begin
      ovfl_out <= adc_ovfl || (s_cnt > SW'(1));
      if (adc_ovfl)               s_cnt <= SW'(STRETCH);
      else if (s_cnt != '0)       s_cnt <= s_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_peak_mon.sv
// Directed bench for adc_peak_mon: windows, saturation, drop/ack, stretch, reset.
module tb_adc_peak_mon;

  logic               adc_clk = 1'b0;
  logic               rst_n;
  logic signed [13:0] adc_data;
  logic               adc_ovfl;
  logic [15:0]        win_len;
  logic               clear;
  logic signed [13:0] data_out;
  logic               ovfl_out;
  logic               snap_valid;
  logic               snap_ack;
  logic [13:0]        snap_peak;
  logic [15:0]        snap_ovfl_cnt;
  logic               snap_lost;

  int nvec = 0;
  int nerr = 0;

  adc_peak_mon #(.ADC_W(14), .STRETCH(4)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .adc_data(adc_data), .adc_ovfl(adc_ovfl),
    .win_len(win_len), .clear(clear), .data_out(data_out), .ovfl_out(ovfl_out),
    .snap_valid(snap_valid), .snap_ack(snap_ack), .snap_peak(snap_peak),
    .snap_ovfl_cnt(snap_ovfl_cnt), .snap_lost(snap_lost)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; adc_data = '0; adc_ovfl = 1'b0; win_len = 16'd3;
    clear = 1'b0; snap_ack = 1'b0;
    #12;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ovfl_out", 32'(ovfl_out), 32'd0);
    chk("rst_valid",    32'(snap_valid), 32'd0);
    chk("rst_peak",     32'(snap_peak), 32'd0);
    chk("rst_cnt",      32'(snap_ovfl_cnt), 32'd0);
    chk("rst_lost",     32'(snap_lost), 32'd0);
    rst_n = 1'b1;

    // win_len=3: 5,-100,7,2 -> snapshot after 4th edge
    adc_data = 14'sd5;    tick(); chk("w3_data_out", 32'(data_out), 32'd5);
    adc_data = -14'sd100; tick();
    adc_data = 14'sd7;    tick(); chk("w3_valid_early", 32'(snap_valid), 32'd0);
    adc_data = 14'sd2;    tick();
    chk("w3_valid", 32'(snap_valid), 32'd1);
    chk("w3_peak",  32'(snap_peak), 32'd100);
    chk("w3_cnt",   32'(snap_ovfl_cnt), 32'd0);
    // ack with no terminal -> valid drops; next window opens on this edge
    snap_ack = 1'b1; adc_data = 14'sd0; tick(); snap_ack = 1'b0;
    chk("ack_valid", 32'(snap_valid), 32'd0);
    // win_len change mid-window must not shorten this window
    win_len = 16'd0;
    adc_data = 14'sd3;  adc_ovfl = 1'b1; tick();
    adc_data = -14'sd9; adc_ovfl = 1'b0; tick();
    chk("midlen_valid", 32'(snap_valid), 32'd0);
    adc_data = 14'sd4;  adc_ovfl = 1'b1; tick(); adc_ovfl = 1'b0;
    chk("w2_valid", 32'(snap_valid), 32'd1);
    chk("w2_peak",  32'(snap_peak), 32'd9);
    chk("w2_cnt",   32'(snap_ovfl_cnt), 32'd2);

    // most negative code magnitude
    pulse_reset(); win_len = 16'd1;
    adc_data = -14'sd8192; tick();
    adc_data = 14'sd0;     tick();
    chk("neg_valid", 32'(snap_valid), 32'd1);
    chk("neg_peak",  32'(snap_peak), 32'd8192);

    // overflow count saturation over a 65536-sample window
    pulse_reset(); win_len = 16'hFFFF; adc_ovfl = 1'b1; adc_data = 14'sd0;
    repeat (65535) tick();
    chk("sat_valid_early", 32'(snap_valid), 32'd0);
    chk("sat_ovfl_out",    32'(ovfl_out), 32'd1);
    tick();
    chk("sat_valid", 32'(snap_valid), 32'd1);
    chk("sat_cnt",   32'(snap_ovfl_cnt), 32'hFFFF);
    adc_ovfl = 1'b0;

    // win_len=0, no ack -> drop keeps first snapshot and sets lost
    pulse_reset(); win_len = 16'd0;
    adc_data = 14'sd10; tick();
    chk("drop_valid1", 32'(snap_valid), 32'd1);
    chk("drop_peak1",  32'(snap_peak), 32'd10);
    chk("drop_lost1",  32'(snap_lost), 32'd0);
    adc_data = 14'sd20; tick();
    chk("drop_peak2",  32'(snap_peak), 32'd10);
    chk("drop_lost2",  32'(snap_lost), 32'd1);
    // ack with clear suppresses the capture -> valid and lost both clear
    snap_ack = 1'b1; clear = 1'b1; adc_data = 14'sd30; tick(); clear = 1'b0;
    chk("ackclr_valid", 32'(snap_valid), 32'd0);
    chk("ackclr_lost",  32'(snap_lost), 32'd0);

    // win_len=0, ack tied high -> continuous valid, peak tracks sample
    adc_data = 14'sd3;    tick(); chk("stream_peak_a", 32'(snap_peak), 32'd3);
    chk("stream_valid_a", 32'(snap_valid), 32'd1);
    adc_data = -14'sd4;   tick(); chk("stream_peak_b", 32'(snap_peak), 32'd4);
    adc_data = 14'sd100;  tick(); chk("stream_peak_c", 32'(snap_peak), 32'd100);
    chk("stream_valid_c", 32'(snap_valid), 32'd1);
    chk("stream_lost",    32'(snap_lost), 32'd0);
    snap_ack = 1'b0;

    // stretch: pulses at edges 10 and 12 -> high through edge 15's output
    pulse_reset(); win_len = 16'hFFFF; adc_data = 14'sd0;
    for (int k = 1; k <= 17; k++) begin
      adc_ovfl = (k == 10 || k == 12);
      tick();
      if (k >= 9) chk($sformatf("stretch_c%0d", k + 1), 32'(ovfl_out),
                      32'((k >= 10 && k <= 15) ? 1 : 0));
    end
    adc_ovfl = 1'b0;

    // clear mid-window discards partial data
    pulse_reset(); win_len = 16'd3;
    adc_data = 14'sd50; tick();
    adc_data = 14'sd60; clear = 1'b1; tick(); clear = 1'b0;
    adc_data = 14'sd1; tick();
    adc_data = 14'sd2; tick();
    adc_data = 14'sd3; tick(); chk("clr_valid_early", 32'(snap_valid), 32'd0);
    adc_data = 14'sd4; tick();
    chk("clr_valid", 32'(snap_valid), 32'd1);
    chk("clr_peak",  32'(snap_peak), 32'd4);

    // async reset mid-window with a pending snapshot
    adc_data = 14'sd999; adc_ovfl = 1'b1; tick();
    rst_n = 1'b0; #1;
    chk("arst_data_out", 32'(data_out), 32'd0);
    chk("arst_ovfl_out", 32'(ovfl_out), 32'd0);
    chk("arst_valid",    32'(snap_valid), 32'd0);
    chk("arst_peak",     32'(snap_peak), 32'd0);
    chk("arst_lost",     32'(snap_lost), 32'd0);
    rst_n = 1'b1; adc_ovfl = 1'b0; win_len = 16'd2;
    adc_data = 14'sd1;  tick();
    adc_data = -14'sd2; tick();
    adc_data = 14'sd3;  tick();
    chk("post_valid", 32'(snap_valid), 32'd1);
    chk("post_peak",  32'(snap_peak), 32'd3);
    chk("post_cnt",   32'(snap_ovfl_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
